// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: in-order register-file writeback queue with read-port forwarding.
// A small circular FIFO of (addr, data) entries, drained one per cycle into the
// register-file write port, with combinational lookup of pending data for two reads.
module gpr_wb_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_addr,
  input  logic [31:0]              in_data,
  input  logic                     hold,
  input  logic                     flush,
  output logic                     rf_we,
  output logic [4:0]               rf_a3,
  output logic [31:0]              rf_wd,
  input  logic [4:0]               rd_a1,
  input  logic [4:0]               rd_a2,
  output logic                     hit1,
  output logic                     hit2,
  output logic [31:0]              fwd1,
  output logic [31:0]              fwd2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_entry_t;

  wb_entry_t        mem [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             push;
  logic             pop;
  logic             not_empty;

  assign count     = cnt;
  assign not_empty = (cnt != '0);

  // Handshake and drain controls, derived from registered state and current inputs
  always_comb begin
    in_ready = (cnt < CW'(DEPTH));
    push     = in_valid & in_ready & (in_addr != 5'd0) & ~flush;
    rf_we    = not_empty & ~hold & ~flush;
    pop      = rf_we;
    rf_a3    = 5'd0;
    rf_wd    = 32'd0;
    if (not_empty) begin
      rf_a3 = mem[head].addr;
      rf_wd = mem[head].data;
    end
  end

  // Pointer and occupancy state; flush clears everything and overrides push/pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= AW'(tail + AW'(1));
      if (pop)  head <= AW'(head + AW'(1));
      unique case ({push, pop})
        2'b10:   cnt <= CW'(cnt + CW'(1));
        2'b01:   cnt <= CW'(cnt - CW'(1));
        default: cnt <= cnt;
      endcase
    end
  end

  // Entry storage; validity is tracked by cnt so contents need no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail].addr <= in_addr;
      mem[tail].data <= in_data;
    end
  end

  // Forwarding scan from oldest to youngest so the youngest match wins
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fwd1 = 32'd0;
    fwd2 = 32'd0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CW'(i) < cnt) begin
        if ((rd_a1 != 5'd0) && (mem[AW'(head + AW'(i))].addr == rd_a1)) begin
          hit1 = 1'b1;
          fwd1 = mem[AW'(head + AW'(i))].data;
        end
        if ((rd_a2 != 5'd0) && (mem[AW'(head + AW'(i))].addr == rd_a2)) begin
          hit2 = 1'b1;
          fwd2 = mem[AW'(head + AW'(i))].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// Directed testbench for gpr_wb_queue (DEPTH = 4).
module tb_gpr_wb_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        hold;
  logic        flush;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic [4:0]  rd_a1;
  logic [4:0]  rd_a2;
  logic        hit1;
  logic        hit2;
  logic [31:0] fwd1;
  logic [31:0] fwd2;
  logic [2:0]  count;

  int vectors;
  int miscompares;

  gpr_wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold), .flush(flush),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd), .rd_a1(rd_a1), .rd_a2(rd_a2),
    .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2), .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL reset_rf_we got %b exp 0", rf_we); end
    vectors++; if (rf_a3 !== 5'd0) begin miscompares++; $display("FAIL reset_rf_a3 got %0d exp 0", rf_a3); end
    vectors++; if (rf_wd !== 32'd0) begin miscompares++; $display("FAIL reset_rf_wd got %h exp 0", rf_wd); end
    vectors++; if ({hit1, hit2} !== 2'b00) begin miscompares++; $display("FAIL reset_hits got %b exp 00", {hit1, hit2}); end
    vectors++; if ({fwd1, fwd2} !== 64'd0) begin miscompares++; $display("FAIL reset_fwd got %h exp 0", {fwd1, fwd2}); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count got %0d exp 0", count); end
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_addr = 5'd5; in_data = 32'h1234_5678; rd_a1 = 5'd5;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b exp 1", in_ready); end
    vectors++; if (hit1 !== 1'b0) begin miscompares++; $display("FAIL single_no_same_cycle_fwd got %b exp 0", hit1); end
    tick();
    in_valid = 1'b0; rd_a1 = 5'd0;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL single_we got %b exp 1", rf_we); end
    vectors++; if (rf_a3 !== 5'd5) begin miscompares++; $display("FAIL single_a3 got %0d exp 5", rf_a3); end
    vectors++; if (rf_wd !== 32'h1234_5678) begin miscompares++; $display("FAIL single_wd got %h exp 12345678", rf_wd); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count1 got %0d exp 1", count); end
    tick();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_count0 got %0d exp 0", count); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL single_we_after got %b exp 0", rf_we); end
  endtask

  task automatic test_fill();
    hold = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_addr = 5'(i); in_data = 32'h100 + 32'(i);
      tick();
    end
    in_addr = 5'd9; in_data = 32'h999;
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_count got %0d exp 4", count); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL fill_ready got %b exp 0", in_ready); end
    tick();
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL fill_reject got %0d exp 4", count); end
    in_valid = 1'b0; hold = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_pop_ready got %b exp 0", in_ready); end
    for (int i = 1; i <= 4; i++) begin
      vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL drain_we[%0d] got %b exp 1", i, rf_we); end
      vectors++; if (rf_a3 !== 5'(i)) begin miscompares++; $display("FAIL drain_a3[%0d] got %0d exp %0d", i, rf_a3, i); end
      vectors++; if (rf_wd !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL drain_wd[%0d] got %h exp %h", i, rf_wd, 32'h100 + 32'(i)); end
      tick();
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL drain_count got %0d exp 0", count); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL drain_idle got %b exp 0", rf_we); end
  endtask

  task automatic test_zero();
    in_valid = 1'b1; in_addr = 5'd0; in_data = 32'hFFFF_FFFF; rd_a1 = 5'd0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL zero_count got %0d exp 0", count); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL zero_we got %b exp 0", rf_we); end
    vectors++; if (hit1 !== 1'b0) begin miscompares++; $display("FAIL zero_hit got %b exp 0", hit1); end
  endtask

  task automatic test_forward();
    hold = 1'b1; in_valid = 1'b1; in_addr = 5'd7; in_data = 32'hA;
    tick();
    in_data = 32'hB;
    tick();
    in_valid = 1'b0; rd_a1 = 5'd7; rd_a2 = 5'd8;
    #1;
    vectors++; if (hit1 !== 1'b1) begin miscompares++; $display("FAIL fwd_hit1 got %b exp 1", hit1); end
    vectors++; if (fwd1 !== 32'hB) begin miscompares++; $display("FAIL fwd_data1 got %h exp b", fwd1); end
    vectors++; if (hit2 !== 1'b0) begin miscompares++; $display("FAIL fwd_hit2 got %b exp 0", hit2); end
    vectors++; if (fwd2 !== 32'h0) begin miscompares++; $display("FAIL fwd_data2 got %h exp 0", fwd2); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL fwd_hold_we got %b exp 0", rf_we); end
    hold = 1'b0;
    #1;
    vectors++; if (rf_wd !== 32'hA) begin miscompares++; $display("FAIL dup_first got %h exp a", rf_wd); end
    tick();
    vectors++; if (rf_wd !== 32'hB) begin miscompares++; $display("FAIL dup_second got %h exp b", rf_wd); end
    vectors++; if (fwd1 !== 32'hB) begin miscompares++; $display("FAIL fwd_head_only got %h exp b", fwd1); end
    tick();
    rd_a1 = 5'd0; rd_a2 = 5'd0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL fwd_drained got %0d exp 0", count); end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  qa[$];
    logic [31:0] qd[$];
    hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_addr = 5'(10 + i); in_data = 32'h200 + 32'(i);
      qa.push_back(in_addr); qd.push_back(in_data);
      tick();
    end
    hold = 1'b0;
    for (int k = 0; k < 12; k++) begin
      in_addr = 5'(1 + (k % 31)); in_data = 32'h300 + 32'(k);
      #1;
      vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL b2b_we[%0d] got %b exp 1", k, rf_we); end
      vectors++; if (rf_a3 !== qa[0]) begin miscompares++; $display("FAIL b2b_a3[%0d] got %0d exp %0d", k, rf_a3, qa[0]); end
      vectors++; if (rf_wd !== qd[0]) begin miscompares++; $display("FAIL b2b_wd[%0d] got %h exp %h", k, rf_wd, qd[0]); end
      qa.push_back(in_addr); qd.push_back(in_data);
      void'(qa.pop_front()); void'(qd.pop_front());
      tick();
      vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL b2b_count[%0d] got %0d exp 3", k, count); end
    end
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (rf_wd !== qd[0]) begin miscompares++; $display("FAIL b2b_tail_wd[%0d] got %h exp %h", k, rf_wd, qd[0]); end
      void'(qa.pop_front()); void'(qd.pop_front());
      tick();
    end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL b2b_end got %0d exp 0", count); end
  endtask

  task automatic test_flush_reset();
    hold = 1'b1; in_valid = 1'b1;
    in_addr = 5'd3; in_data = 32'h33; tick();
    in_addr = 5'd4; in_data = 32'h44; tick();
    in_addr = 5'd9; in_data = 32'hDEAD; flush = 1'b1; hold = 1'b0;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_we got %b exp 0", rf_we); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL flush_count got %0d exp 0", count); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_no_write got %b exp 0", rf_we); end
    tick();
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL flush_idle got %b exp 0", rf_we); end

    hold = 1'b1; in_valid = 1'b1;
    in_addr = 5'd3; in_data = 32'h33; tick();
    in_addr = 5'd4; in_data = 32'h44; tick();
    in_valid = 1'b0; hold = 1'b0;
    #1;
    vectors++; if (rf_we !== 1'b1) begin miscompares++; $display("FAIL pre_rst_we got %b exp 1", rf_we); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL rst_count got %0d exp 0", count); end
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got %b exp 0", rf_we); end
    vectors++; if (rf_a3 !== 5'd0) begin miscompares++; $display("FAIL rst_a3 got %0d exp 0", rf_a3); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", in_ready); end
    tick();
    rst = 1'b1;
    #1;
    vectors++; if (rf_we !== 1'b0) begin miscompares++; $display("FAIL post_rst_we got %b exp 0", rf_we); end
    in_valid = 1'b1; in_addr = 5'd6; in_data = 32'h66;
    tick();
    in_valid = 1'b0;
    vectors++; if (rf_wd !== 32'h66) begin miscompares++; $display("FAIL resume_wd got %h exp 66", rf_wd); end
    vectors++; if (rf_a3 !== 5'd6) begin miscompares++; $display("FAIL resume_a3 got %0d exp 6", rf_a3); end
    tick();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL resume_count got %0d exp 0", count); end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; in_valid = 1'b0; in_addr = 5'd0; in_data = 32'd0;
    hold = 1'b0; flush = 1'b0; rd_a1 = 5'd0; rd_a2 = 5'd0;
    test_reset();
    test_single();
    test_fill();
    test_zero();
    test_forward();
    test_back_to_back();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
